// File: rtl/seq_divider.sv
// seq_divider: restoring radix-2 sequential unsigned divider with divide-by-zero flag
module seq_divider #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_data_in,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             valid_data_out,
   output logic             busy,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] dvd, dvs, rem, rem_nxt;
   logic [WIDTH:0] shifted;
   logic [CW-1:0] cnt;
   logic ge, last, accept;
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
      ge = shifted >= {1'b0, dvs};
      rem_nxt = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
      last = cnt == CW'(WIDTH - 1);
      accept = state == IDLE && valid_data_in;
      state_nxt = state == IDLE ? (valid_data_in ? (in2 == '0 ? DONE : CALC) : IDLE) :
                  state == CALC ? (last ? DONE : CALC) : IDLE;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
         cnt <= '0;
      end else if (accept) begin
         dvd <= in1;
         dvs <= in2;
         rem <= '0;
         cnt <= '0;
         if (in2 == '0) begin
            quotient <= '1;
            remainder <= in1;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         dvd <= {dvd[WIDTH-2:0], ge};
         rem <= rem_nxt;
         cnt <= cnt + 1'b1;
         if (last) begin
            quotient <= {dvd[WIDTH-2:0], ge};
            remainder <= rem_nxt;
            div_by_zero <= 1'b0;
         end
      end
   end
   assign valid_data_out = state == DONE;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against plain / and % arithmetic
module tb_seq_divider;
   localparam int W = 24;
   logic clk = 1'b0, rst = 1'b1, valid_data_in = 1'b0;
   logic [W-1:0] in1 = '0, in2 = '0;
   logic [W-1:0] quotient, remainder;
   logic valid_data_out, busy, div_by_zero;
   int n_checks = 0, n_fails = 0;
   always #5 clk = ~clk;
   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid_data_in(valid_data_in), .in1(in1), .in2(in2),
      .quotient(quotient), .remainder(remainder), .valid_data_out(valid_data_out),
      .busy(busy), .div_by_zero(div_by_zero)
   );
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 100) begin n_fails++; $display("FAIL issue_wait: busy=%b required 0", busy); end
      in1 = a;
      in2 = b;
      valid_data_in = 1'b1;
      @(posedge clk);
      #1 valid_data_in = 1'b0;
      in1 = W'($urandom);
      in2 = W'($urandom);
   endtask
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (valid_data_out) begin
            lat = k;
            break;
         end
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      valid_data_in = 1'b1;
      in1 = 100;
      in2 = 7;
      repeat (3) @(negedge clk);
      n_checks++; if ({quotient, remainder} !== '0) begin n_fails++; $display("FAIL reset_qr: got %h/%h required 0/0", quotient, remainder); end
      n_checks++; if ({valid_data_out, busy, div_by_zero} !== 3'b000) begin n_fails++; $display("FAIL reset_flags: got %b required 000", {valid_data_out, busy, div_by_zero}); end
      rst = 1'b0;
      valid_data_in = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_idle: busy=%b required 0", busy); end
   endtask
   task automatic test_basic;
      int lat;
      issue(100, 7);
      wait_valid(lat);
      n_checks++; if (lat != W) begin n_fails++; $display("FAIL basic_latency: got %0d required %0d", lat, W); end
      n_checks++; if ({quotient, remainder, div_by_zero} !== {24'd14, 24'd2, 1'b0}) begin n_fails++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b required 14 2 0", quotient, remainder, div_by_zero); end
      @(negedge clk);
      n_checks++; if ({valid_data_out, busy} !== 2'b00) begin n_fails++; $display("FAIL basic_pulse: valid,busy=%b required 00", {valid_data_out, busy}); end
   endtask
   task automatic test_extremes;
      int lat;
      issue(24'hFFFFFF, 1);
      wait_valid(lat);
      n_checks++; if ({quotient, remainder, lat} !== {24'hFFFFFF, 24'h0, W}) begin n_fails++; $display("FAIL ext_max_by_1: got q=%h r=%h lat=%0d required FFFFFF 0 %0d", quotient, remainder, lat, W); end
      issue(5, 24'hFFFFFF);
      wait_valid(lat);
      n_checks++; if ({quotient, remainder, lat} !== {24'h0, 24'h5, W}) begin n_fails++; $display("FAIL ext_5_by_max: got q=%h r=%h lat=%0d required 0 5 %0d", quotient, remainder, lat, W); end
   endtask
   task automatic test_div_zero;
      int lat;
      issue(24'h00ABCD, 0);
      wait_valid(lat);
      n_checks++; if (lat != 0) begin n_fails++; $display("FAIL dz_latency: got %0d required 0", lat); end
      n_checks++; if ({quotient, remainder, div_by_zero} !== {24'hFFFFFF, 24'h00ABCD, 1'b1}) begin n_fails++; $display("FAIL dz_result: got q=%h r=%h dz=%b required FFFFFF 00ABCD 1", quotient, remainder, div_by_zero); end
      @(negedge clk);
      n_checks++; if (valid_data_out !== 1'b0) begin n_fails++; $display("FAIL dz_pulse: valid=%b required 0", valid_data_out); end
      issue(9, 3);
      repeat (5) @(negedge clk);
      n_checks++; if ({busy, quotient, div_by_zero} !== {1'b1, 24'hFFFFFF, 1'b1}) begin n_fails++; $display("FAIL dz_hold: got busy=%b q=%h dz=%b required 1 FFFFFF 1", busy, quotient, div_by_zero); end
      wait_valid(lat);
      n_checks++; if ({quotient, remainder, div_by_zero, lat} !== {24'd3, 24'd0, 1'b0, W - 5}) begin n_fails++; $display("FAIL dz_clear: got q=%0d r=%0d dz=%b lat=%0d required 3 0 0 %0d", quotient, remainder, div_by_zero, lat, W - 5); end
   endtask
   task automatic test_busy_refusal;
      int lat, pulses = 0;
      issue(1000, 10);
      repeat (4) @(negedge clk);
      in1 = 50;
      in2 = 5;
      valid_data_in = 1'b1;
      @(negedge clk);
      valid_data_in = 1'b0;
      wait_valid(lat);
      n_checks++; if ({quotient, remainder, lat} !== {24'd100, 24'd0, W - 5}) begin n_fails++; $display("FAIL busy_result: got q=%0d r=%0d lat=%0d required 100 0 %0d", quotient, remainder, lat, W - 5); end
      repeat (40) begin
         @(negedge clk);
         pulses += int'(valid_data_out);
      end
      n_checks++; if (pulses != 0 || busy !== 1'b0) begin n_fails++; $display("FAIL busy_dropped: got pulses=%0d busy=%b required 0 0", pulses, busy); end
   endtask
   task automatic test_reset_mid;
      int lat;
      issue(12345, 7);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({quotient, remainder, valid_data_out, busy, div_by_zero} !== '0) begin n_fails++; $display("FAIL mid_reset: got q=%h r=%h v=%b b=%b dz=%b required all 0", quotient, remainder, valid_data_out, busy, div_by_zero); end
      rst = 1'b0;
      issue(81, 9);
      n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL mid_accept: busy=%b required 1", busy); end
      wait_valid(lat);
      n_checks++; if ({quotient, remainder, lat} !== {24'd9, 24'd0, W}) begin n_fails++; $display("FAIL mid_next: got q=%0d r=%0d lat=%0d required 9 0 %0d", quotient, remainder, lat, W); end
   endtask
   task automatic test_back_to_back;
      int lat, bad = 0;
      logic [W-1:0] a, b, eq, er;
      logic ez;
      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom >> $urandom_range(0, 8));
         case ($urandom_range(0, 9))
            0: b = '0;
            1: b = 1;
            default: b = W'($urandom >> $urandom_range(0, 31));
         endcase
         ez = b == 0;
         eq = ez ? '1 : a / b;
         er = ez ? a : a % b;
         issue(a, b);
         wait_valid(lat);
         n_checks++;
         if ({quotient, remainder, div_by_zero} !== {eq, er, ez} || lat != (ez ? 0 : W)) begin
            n_fails++;
            bad++;
            $display("FAIL random %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d required %0d %0d %b %0d", a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, ez ? 0 : W);
         end
      end
      $display("random regression: 1000 ops, %0d passed, %0d bad", 1000 - bad, bad);
   endtask
   initial begin
      test_reset;
      test_basic;
      test_extremes;
      test_div_zero;
      test_busy_refusal;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
